// File: rtl/arb8_rr_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// arb8_rr_if : request/grant/ack bundle between arb8_rr and its eight clients
// Revision   : 1.0
// ----------------------------------------------------------------------------
interface arb8_rr_if;
  logic [7:0] req;
  logic       res_resp;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       res_req;
  logic [7:0] ack;
  logic       timeout;

  modport master (
    input  req, res_resp,
    output sel, gnt, res_req, ack, timeout
  );

  modport slave (
    output req, res_resp,
    input  sel, gnt, res_req, ack, timeout
  );
endinterface
`default_nettype wire

// File: rtl/arb8_rr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// arb8_rr  : 8-way round-robin arbiter for one shared resource, optional hold timeout
// Revision : 1.0
// ----------------------------------------------------------------------------
module arb8_rr #(
  parameter int MAX_HOLD = 0
) (
  input  wire logic clk,
  input  wire logic rst_n,
  arb8_rr_if.master bus
);

  localparam int C_CNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [C_CNT_W-1:0] C_HOLD_LAST = C_CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]         r_state, w_state_nxt;
  logic [2:0]         r_ptr, w_ptr_nxt;
  logic [C_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]         r_sel, w_sel_nxt;
  logic [7:0]         r_gnt, w_gnt_nxt;
  logic [7:0]         r_ack, w_ack_nxt;
  logic               r_res_req, w_res_req_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic [2:0]         w_pick;
  logic               w_expire;

  // Scanning offsets high-to-low leaves the nearest set request at or after r_ptr.
  always_comb begin
    w_pick = r_ptr;
    for (int i = 7; i >= 0; i--) begin
      if (bus.req[r_ptr + 3'(i)]) begin
        w_pick = r_ptr + 3'(i);
      end
    end
  end

  assign w_expire = (MAX_HOLD != 0) && (r_cnt == C_HOLD_LAST) && !bus.res_resp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (|bus.req) w_state_nxt = S_BUSY;
      S_BUSY:    if (bus.res_resp || w_expire) w_state_nxt = S_RELEASE;
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // r_sel doubles as the latched winner, so it naturally holds through IDLE/RELEASE.
  always_comb begin
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_sel_nxt     = r_sel;
    w_gnt_nxt     = 8'h00;
    w_ack_nxt     = 8'h00;
    w_res_req_nxt = 1'b0;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|bus.req) begin
          w_sel_nxt     = w_pick;
          w_gnt_nxt     = 8'b1 << w_pick;
          w_res_req_nxt = 1'b1;
          w_ptr_nxt     = w_pick + 3'd1;
          w_cnt_nxt     = '0;
        end
      end
      S_BUSY: begin
        if (bus.res_resp || w_expire) begin
          w_ack_nxt     = 8'b1 << r_sel;
          w_timeout_nxt = w_expire;
        end else begin
          w_gnt_nxt     = 8'b1 << r_sel;
          w_res_req_nxt = 1'b1;
          w_cnt_nxt     = r_cnt + 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= 3'd0;
      r_cnt     <= '0;
      r_sel     <= 3'd0;
      r_gnt     <= 8'h00;
      r_ack     <= 8'h00;
      r_res_req <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sel     <= w_sel_nxt;
      r_gnt     <= w_gnt_nxt;
      r_ack     <= w_ack_nxt;
      r_res_req <= w_res_req_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign bus.sel     = r_sel;
  assign bus.gnt     = r_gnt;
  assign bus.ack     = r_ack;
  assign bus.res_req = r_res_req;
  assign bus.timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_arb8_rr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_arb8_rr : directed and randomized scoreboard bench for arb8_rr (MAX_HOLD=4)
// Revision   : 1.0
// ----------------------------------------------------------------------------
module tb_arb8_rr;
  localparam int MAX_HOLD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arb8_rr_if bus ();
  arb8_rr #(.MAX_HOLD(MAX_HOLD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

  typedef struct {
    int cyc;
    int who;
    bit to;
  } ev_t;

  ev_t  gq[$];
  ev_t  aq[$];
  int   glog[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference model: who owns the resource, for how long, and where the rotation stands.
  bit   m_busy = 1'b0;
  bit   m_rel  = 1'b0;
  int   m_held = 0;
  int   m_w    = 0;
  int   m_ptr  = 0;
  ev_t  mod_e;
  ev_t  mon_e;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input int info);
    checks++;
    failures++;
    $display("FAIL %s: info %0d (cycle %0d)", name, info, cyc);
  endtask

  function automatic int rr_pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      cyc++;
      if (m_rel) begin
        m_rel = 1'b0;
      end else if (m_busy) begin
        m_held++;
        if (bus.res_resp || m_held == MAX_HOLD) begin
          mod_e.cyc = cyc;
          mod_e.who = m_w;
          mod_e.to  = !bus.res_resp;
          aq.push_back(mod_e);
          m_busy = 1'b0;
          m_rel  = 1'b1;
        end
      end else if (bus.req != 8'h00) begin
        m_w    = rr_pick(bus.req, m_ptr);
        m_ptr  = (m_w + 1) % 8;
        m_busy = 1'b1;
        m_held = 0;
        mod_e.cyc = cyc;
        mod_e.who = m_w;
        mod_e.to  = 1'b0;
        gq.push_back(mod_e);
      end
    end
  end

  logic [7:0] prev_gnt = 8'h00;

  always @(negedge rst_n) begin
    m_busy = 1'b0;
    m_rel  = 1'b0;
    m_held = 0;
    m_w    = 0;
    m_ptr  = 0;
    gq.delete();
    aq.delete();
    prev_gnt = 8'h00;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("gnt_level", int'(bus.gnt), m_busy ? (1 << m_w) : 0);
      chk("res_req_level", int'(bus.res_req), int'(m_busy));
      chk("sel_level", int'(bus.sel), m_w);
      if (gq.size() != 0 && gq[0].cyc < cyc) begin
        fail_now("grant_missing_for", gq[0].who);
        void'(gq.pop_front());
      end
      if (aq.size() != 0 && aq[0].cyc < cyc) begin
        fail_now("ack_missing_for", aq[0].who);
        void'(aq.pop_front());
      end
      if (bus.gnt != 8'h00 && prev_gnt == 8'h00) begin
        if (gq.size() == 0) begin
          fail_now("unexpected_grant", int'(bus.gnt));
        end else begin
          mon_e = gq.pop_front();
          chk("grant_cycle", cyc, mon_e.cyc);
          chk("grant_sel", int'(bus.sel), mon_e.who);
        end
        glog.push_back(int'(bus.sel));
      end
      if (bus.ack != 8'h00) begin
        if (aq.size() == 0) begin
          fail_now("unexpected_ack", int'(bus.ack));
        end else begin
          mon_e = aq.pop_front();
          chk("ack_cycle", cyc, mon_e.cyc);
          chk("ack_value", int'(bus.ack), 1 << mon_e.who);
          chk("ack_timeout", int'(bus.timeout), int'(mon_e.to));
          chk("ack_gnt_zero", int'(bus.gnt), 0);
        end
      end else if (bus.timeout) begin
        fail_now("timeout_without_ack", 1);
      end
      prev_gnt = bus.gnt;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n        = 1'b0;
    bus.req      = 8'h00;
    bus.res_resp = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    glog.delete();
  endtask

  task automatic wait_grants(input int n, input int budget);
    int k;
    k = 0;
    while (glog.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (glog.size() < n) fail_now("grant_wait_expired", n);
  endtask

  task automatic drain();
    bus.req      = 8'h00;
    bus.res_resp = 1'b1;
    repeat (6) @(negedge clk);
    bus.res_resp = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  busy_n;
    bit  seen;
    logic [7:0] r;
    int  div;

    bus.req      = 8'h00;
    bus.res_resp = 1'b0;
    do_reset();
    chk("rst_gnt", int'(bus.gnt), 0);
    chk("rst_sel", int'(bus.sel), 0);
    chk("rst_ack", int'(bus.ack), 0);
    chk("rst_res_req", int'(bus.res_req), 0);
    chk("rst_timeout", int'(bus.timeout), 0);

    // Single request, completion on the last BUSY edge
    bus.req = 8'h08;
    @(negedge clk); #1;
    chk("single_gnt", int'(bus.gnt), 8'h08);
    chk("single_sel", int'(bus.sel), 3);
    chk("single_res_req", int'(bus.res_req), 1);
    repeat (3) @(negedge clk);
    bus.res_resp = 1'b1;
    @(negedge clk); #1;
    bus.res_resp = 1'b0;
    chk("single_ack", int'(bus.ack), 8'h08);
    chk("single_gnt_rel", int'(bus.gnt), 0);
    chk("single_res_req_rel", int'(bus.res_req), 0);
    chk("single_timeout", int'(bus.timeout), 0);
    bus.req = 8'h00;
    @(negedge clk); #1;
    chk("single_idle_ack", int'(bus.ack), 0);
    chk("single_idle_gnt", int'(bus.gnt), 0);
    chk("single_idle_sel", int'(bus.sel), 3);

    // Fairness with all requesters re-asserting
    do_reset();
    bus.req      = 8'hFF;
    bus.res_resp = 1'b1;
    wait_grants(9, 60);
    drain();
    for (int i = 0; i < 9; i++) begin
      chk("fair_order", (i < glog.size()) ? glog[i] : -1, i % 8);
    end

    // Wrap from 7 back to 0 and on to 7
    do_reset();
    bus.req      = 8'h80;
    bus.res_resp = 1'b1;
    wait_grants(1, 20);
    bus.req = 8'h81;
    wait_grants(3, 40);
    drain();
    chk("wrap_0", (glog.size() > 0) ? glog[0] : -1, 7);
    chk("wrap_1", (glog.size() > 1) ? glog[1] : -1, 0);
    chk("wrap_2", (glog.size() > 2) ? glog[2] : -1, 7);

    // Forced release after MAX_HOLD BUSY cycles
    do_reset();
    bus.req = 8'h04;
    wait_grants(1, 10);
    busy_n = 0;
    seen   = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      if (bus.ack != 8'h00) begin
        seen = 1'b1;
        chk("to_ack", int'(bus.ack), 8'h04);
        chk("to_flag", int'(bus.timeout), 1);
      end else begin
        if (bus.gnt != 8'h00) busy_n++;
        @(negedge clk); #1;
      end
    end
    chk("to_seen", int'(seen), 1);
    chk("to_busy_cycles", busy_n, MAX_HOLD);
    bus.req = 8'h00;
    @(negedge clk); #1;
    chk("to_pulse_width", int'(bus.timeout), 0);

    // Requester drops mid-BUSY; grant holds until the response
    do_reset();
    bus.req = 8'h24;
    wait_grants(1, 10);
    @(negedge clk); #1;
    bus.req = 8'h20;
    @(negedge clk); #1;
    chk("drop_hold_gnt", int'(bus.gnt), 8'h04);
    bus.res_resp = 1'b1;
    @(negedge clk); #1;
    bus.res_resp = 1'b0;
    chk("drop_ack", int'(bus.ack), 8'h04);
    wait_grants(2, 10);
    chk("drop_next", (glog.size() > 1) ? glog[1] : -1, 5);
    drain();

    // Asynchronous reset between edges while BUSY
    do_reset();
    bus.req = 8'h02;
    wait_grants(1, 10);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", int'(bus.gnt), 0);
    chk("arst_res_req", int'(bus.res_req), 0);
    chk("arst_sel", int'(bus.sel), 0);
    chk("arst_ack", int'(bus.ack), 0);
    bus.req = 8'h30;
    #1;
    rst_n = 1'b1;
    glog.delete();
    wait_grants(1, 5);
    chk("arst_regrant", (glog.size() > 0) ? glog[0] : -1, 4);
    drain();

    // Randomized traffic: mostly quick completions, then slow ones that hit the timeout
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk); #1;
      div = (n < 1500) ? 3 : 9;
      r = bus.req;
      for (int i = 0; i < 8; i++) begin
        if (r[i] && bus.ack[i])                                    r[i] = ($urandom_range(0, 3) == 0);
        else if (!r[i] && $urandom_range(0, 7) == 0)               r[i] = 1'b1;
        else if (r[i] && bus.gnt[i] && $urandom_range(0, 31) == 0) r[i] = 1'b0;
      end
      bus.req      = r;
      bus.res_resp = bus.res_req ? ($urandom_range(0, div - 1) == 0) : ($urandom_range(0, 1) == 1);
    end
    drain();
    chk("pending_grants", gq.size(), 0);
    chk("pending_acks", aq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
